// File: rtl/writeback_stage.sv
// Write-back stage: in-order DEPTH-entry buffer in front of the register-file write port,
// with rs forwarding lookup and retired-instruction counter. Optional macro: WB_BYPASS_EN.
module writeback_stage #(
    parameter int N         = 32,
    parameter int DEPTH     = 2,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           i_wb_rd,
    input  logic [6:0]           i_opcode,
    input  logic [N-1:0]         i_wb_data,
    input  logic                 i_mem_vld,
    output logic                 o_stall,
    output logic                 o_rf_we,
    output logic [4:0]           o_rf_waddr,
    output logic [N-1:0]         o_rf_wdata,
    input  logic                 i_rf_ready,
    input  logic [4:0]           i_fwd_rs,
    output logic                 o_fwd_hit,
    output logic [N-1:0]         o_fwd_data,
    output logic [INSTRET_W-1:0] o_instret
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [4:0]   rd;
        logic [N-1:0] data;
        logic         we;
    } entry_t;

    entry_t               mem_q [DEPTH];
    logic [DEPTH-1:0]     vld_q, vld_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;

    entry_t     head, in_entry;
    logic       head_vld, full, accept, fifo_pop, push, byp_retire;
    logic [1:0] retire_cnt;

    // Only register-writing opcodes with a non-zero destination produce a write.
    function automatic logic writes_rf(input logic [6:0] op, input logic [4:0] rd);
        case (op)
            7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
            7'b1100111, 7'b0110111, 7'b0010111: return rd != 5'd0;
            default:                            return 1'b0;
        endcase
    endfunction

    always_comb begin
        in_entry = '{rd: i_wb_rd, data: i_wb_data, we: writes_rf(i_opcode, i_wb_rd)};
        head     = mem_q[rd_ptr_q];
        head_vld = vld_q[rd_ptr_q];
        full     = (count_q == CNT_W'(DEPTH));
        accept   = i_mem_vld & ~full;
        fifo_pop = head_vld & (~head.we | i_rf_ready);
    end

    // The port is free for a bypassing instruction only if the FIFO does not need it this cycle.
    always_comb begin
        o_rf_we    = head_vld & head.we;
        o_rf_waddr = head_vld ? head.rd   : 5'd0;
        o_rf_wdata = head_vld ? head.data : '0;
        push       = accept;
        byp_retire = 1'b0;
`ifdef WB_BYPASS_EN
        if (accept && ((count_q == '0) ||
                       ((count_q == CNT_W'(1)) && fifo_pop && !head.we))) begin
            o_rf_we    = in_entry.we;
            o_rf_waddr = in_entry.rd;
            o_rf_wdata = in_entry.data;
            byp_retire = ~in_entry.we | i_rf_ready;
            push       = ~byp_retire;
        end
`endif
    end

    always_comb begin
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (fifo_pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        count_d    = count_q + CNT_W'(push) - CNT_W'(fifo_pop);
        retire_cnt = 2'(fifo_pop) + 2'(byp_retire);
        instret_d  = instret_q + INSTRET_W'(retire_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            instret_q <= '0;
        end else begin
            vld_q     <= vld_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            instret_q <= instret_d;
        end
    end

    // NOTE: entry payload is not reset; the valid bits alone decide whether an entry is live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        logic             hit;
        logic [PTR_W-1:0] idx;
        hit        = 1'b0;
        idx        = '0;
        o_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (vld_q[idx] && mem_q[idx].we && (mem_q[idx].rd == i_fwd_rs)) begin
                hit        = 1'b1;
                o_fwd_data = mem_q[idx].data;
            end
        end
        o_fwd_hit = hit & (i_fwd_rs != 5'd0);
    end

    assign o_stall   = full;
    assign o_instret = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage (default build, WB_BYPASS_EN undefined).
module tb_writeback_stage;

    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  i_wb_rd, i_fwd_rs, o_rf_waddr;
    logic [6:0]  i_opcode;
    logic [31:0] i_wb_data, o_rf_wdata, o_fwd_data;
    logic        i_mem_vld, o_stall, o_rf_we, i_rf_ready, o_fwd_hit;
    logic [63:0] o_instret;

    writeback_stage dut (
        .clk(clk), .rst(rst), .i_wb_rd(i_wb_rd), .i_opcode(i_opcode),
        .i_wb_data(i_wb_data), .i_mem_vld(i_mem_vld), .o_stall(o_stall),
        .o_rf_we(o_rf_we), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
        .i_rf_ready(i_rf_ready), .i_fwd_rs(i_fwd_rs), .o_fwd_hit(o_fwd_hit),
        .o_fwd_data(o_fwd_data), .o_instret(o_instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
    } ent_t;

    ent_t        sb[$];
    logic [4:0]  wr_log[$];
    longint      exp_instret = 0;
    int          n_checks = 0;
    int          n_errs = 0;
    bit          mon_en = 0;
    bit          we_any = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_we(input logic [6:0] op, input logic [4:0] rd);
        return (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                           7'b1100111, 7'b0110111, 7'b0010111}) && (rd != 0);
    endfunction

    // Mid-cycle monitor: compare outputs with the model, then advance the model to the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            bit          full, pop, found;
            logic [31:0] fdata;
            full  = (sb.size() == 2);
            found = 0;
            fdata = 0;
            check("stall", o_stall, full);
            check("rf_we", o_rf_we, (sb.size() > 0) ? sb[0].we : 1'b0);
            check("waddr", o_rf_waddr, (sb.size() > 0) ? sb[0].rd : 5'd0);
            check("wdata", o_rf_wdata, (sb.size() > 0) ? sb[0].data : 32'd0);
            for (int i = sb.size() - 1; i >= 0; i--)
                if (!found && sb[i].we && sb[i].rd == i_fwd_rs) begin
                    found = 1;
                    fdata = sb[i].data;
                end
            check("fwd_hit", o_fwd_hit, found && (i_fwd_rs != 0));
            check("fwd_data", o_fwd_data, fdata);
            check("instret", o_instret, exp_instret);
            if (o_rf_we) we_any = 1;
            if (o_rf_we && i_rf_ready) wr_log.push_back(o_rf_waddr);
            if (rst) begin
                sb.delete();
                exp_instret = 0;
            end else begin
                pop = (sb.size() > 0) && (!sb[0].we || i_rf_ready);
                if (pop) begin
                    void'(sb.pop_front());
                    exp_instret++;
                end
                if (i_mem_vld && !full)
                    sb.push_back('{rd: i_wb_rd, data: i_wb_data, we: model_we(i_opcode, i_wb_rd)});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [6:0] op,
                         input logic [31:0] d);
        i_mem_vld = v;
        i_wb_rd   = rd;
        i_opcode  = op;
        i_wb_data = d;
    endtask

    // Hold an instruction until it is accepted, bounded by a cycle budget.
    task automatic send(input logic [4:0] rd, input logic [6:0] op, input logic [31:0] d);
        bit ok = 0;
        drive(1'b1, rd, op, d);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (!o_stall) ok = 1;
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        i_mem_vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        i_rf_ready = 1'b1;
        i_fwd_rs   = 5'd0;
        drive(1'b0, 5'd0, 7'd0, 32'd0);
        @(posedge clk);
        #1;
        mon_en = 1;
        step(1);
        rst = 1'b0;
        step(2);

        // 1: idle after reset
        @(negedge clk);
        check("t1_stall", o_stall, 0);
        check("t1_we", o_rf_we, 0);
        check("t1_instret", o_instret, 0);
        step(1);

        // 2: single ADDI, one cycle latency
        send(5'd5, OP_ADDI, 32'h1234);
        @(negedge clk);
        check("t2_we", o_rf_we, 1);
        check("t2_waddr", o_rf_waddr, 5);
        check("t2_wdata", o_rf_wdata, 32'h1234);
        step(1);
        @(negedge clk);
        check("t2_instret", o_instret, 1);
        step(1);

        // 3: back-pressure and in-order drain
        i_rf_ready = 1'b0;
        wr_log.delete();
        send(5'd3, OP_R, 32'h33);
        send(5'd4, OP_R, 32'h44);
        drive(1'b1, 5'd6, OP_R, 32'h66);
        step(3);
        @(negedge clk);
        check("t3_stall", o_stall, 1);
        step(1);
        i_rf_ready = 1'b1;
        send(5'd6, OP_R, 32'h66);
        step(4);
        check("t3_nwrites", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            check("t3_order0", wr_log[0], 3);
            check("t3_order1", wr_log[1], 4);
            check("t3_order2", wr_log[2], 6);
        end

        // 4: forwarding picks the youngest match; rs=0 never hits
        i_rf_ready = 1'b0;
        send(5'd7, OP_ADDI, 32'hAA);
        send(5'd7, OP_ADDI, 32'hBB);
        i_fwd_rs = 5'd7;
        @(negedge clk);
        check("t4_hit", o_fwd_hit, 1);
        check("t4_data", o_fwd_data, 32'hBB);
        step(1);
        i_fwd_rs = 5'd0;
        @(negedge clk);
        check("t4_hit_rs0", o_fwd_hit, 0);
        step(1);
        i_rf_ready = 1'b1;
        step(4);

        // 5: non-writing instructions retire without ready and without a write
        i_rf_ready = 1'b0;
        we_any = 0;
        send(5'd9, OP_STORE, 32'h99);
        send(5'd0, OP_ADDI, 32'h55);
        step(3);
        @(negedge clk);
        check("t5_instret", o_instret, 8);
        check("t5_no_write", we_any, 0);
        step(1);

        // 6: reset mid-stream drops buffered entries
        send(5'd10, OP_R, 32'hA0);
        send(5'd11, OP_R, 32'hB0);
        drive(1'b1, 5'd12, OP_R, 32'hC0);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        i_mem_vld = 1'b0;
        i_rf_ready = 1'b1;
        wr_log.delete();
        @(negedge clk);
        check("t6_instret", o_instret, 0);
        check("t6_stall", o_stall, 0);
        step(5);
        check("t6_no_stale", wr_log.size(), 0);
        check("t6_instret_end", o_instret, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errs);
        $finish;
    end

endmodule
